// File: rtl/cpu_memory_arbiter_pkg.sv
// Shared definitions for the CPU / diagnostics memory arbiter: state encoding,
// timing defaults and the diagnostics command byte values.
package cpu_memory_arbiter_pkg;

    typedef enum logic [2:0] {
        CPU_IDLE   = 3'd0,
        CPU_ACTIVE = 3'd1,
        DRAIN      = 3'd2,
        DIAG_OWN   = 3'd3,
        RELEASE    = 3'd4
    } arb_state_e;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int DRAIN_TIMEOUT_DEF = 64;

    localparam logic [7:0] HALT_CPU     = 8'haa;
    localparam logic [7:0] RESUME_CPU   = 8'h55;
    localparam logic [7:0] READ_MEMORY  = 8'h66;
    localparam logic [7:0] WRITE_MEMORY = 8'h99;

endpackage

// File: rtl/cpu_memory_arbiter_sync_edge_detect.sv
// N-stage synchroniser for an asynchronous level, with rise/fall pulses taken
// from the last stage against its previous value.
module sync_edge_detect
    import cpu_memory_arbiter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // shift the raw input into the chain and remember the previous output level
    always_comb begin
        sync_d = (sync_q << 1) | {{(STAGES-1){1'b0}}, d};
        prev_d = sync_q[STAGES-1];
    end

    // synchroniser and history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cpu_memory_arbiter.sv
// Arbitrates the shared 64 KiB memory between the 8-bit CPU bus and the
// diagnostics port, switching owners only at CPU bus-cycle boundaries.
module cpu_memory_arbiter
    import cpu_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic                  fpga_clk,
    input  logic                  fpga_reset,
    input  logic                  cpu_phi2,
    input  logic                  cpu_rw,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_data_oe,
    input  logic                  halt,
    output logic                  diag_grant,
    input  logic [ADDR_WIDTH-1:0] diag_address,
    input  logic [7:0]            diag_wdata,
    input  logic                  diag_we,
    input  logic                  diag_cs,
    output logic [7:0]            diag_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_cs,
    input  logic [7:0]            mem_rdata
);

    localparam int              CNT_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    logic phi2_lvl_s, phi2_rise_s, phi2_fall_s;
    logic rw_lvl_s, rw_rise_unused, rw_fall_unused;
    logic own_s;

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  drain_ready_q, drain_ready_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [7:0]            dout_q, dout_d;
    logic                  grant_q, grant_d;
    logic [7:0]            drdata_q, drdata_d;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_phi2_sync (
        .clk(fpga_clk), .rst_n(fpga_reset), .d(cpu_phi2),
        .level(phi2_lvl_s), .rise(phi2_rise_s), .fall(phi2_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_rw_sync (
        .clk(fpga_clk), .rst_n(fpga_reset), .d(cpu_rw),
        .level(rw_lvl_s), .rise(rw_rise_unused), .fall(rw_fall_unused)
    );

    // state and datapath registers
    always_ff @(posedge fpga_clk or negedge fpga_reset) begin
        if (!fpga_reset) begin
            state_q       <= CPU_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            drain_ready_q <= 1'b0;
            rd_ready_q    <= 1'b0;
            rw_q          <= 1'b0;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            wdata_q       <= 8'h00;
            cs_q          <= 1'b0;
            we_q          <= 1'b0;
            oe_q          <= 1'b0;
            dout_q        <= 8'h00;
            grant_q       <= 1'b0;
            drdata_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            drain_ready_q <= drain_ready_d;
            rd_ready_q    <= rd_ready_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cs_q          <= cs_d;
            we_q          <= we_d;
            oe_q          <= oe_d;
            dout_q        <= dout_d;
            grant_q       <= grant_d;
            drdata_q      <= drdata_d;
        end
    end

    // next-state logic; a phi2 rise in CPU_IDLE outranks a simultaneous halt
    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_IDLE: begin
                if (phi2_rise_s)                 state_d = CPU_ACTIVE;
                else if (halt && !phi2_lvl_s)    state_d = DRAIN;
                else                             state_d = CPU_IDLE;
            end
            CPU_ACTIVE: begin
                if (phi2_fall_s)                 state_d = halt ? DRAIN : CPU_IDLE;
                else                             state_d = CPU_ACTIVE;
            end
            DRAIN: begin
                if (!halt)                       state_d = CPU_IDLE;
                else if (drain_ready_q || phi2_fall_s || (cnt_q == CNT_LAST))
                                                 state_d = DIAG_OWN;
                else                             state_d = DRAIN;
            end
            DIAG_OWN: begin
                if (!halt)                       state_d = RELEASE;
                else                             state_d = DIAG_OWN;
            end
            RELEASE: begin
                if (!phi2_lvl_s)                 state_d = CPU_IDLE;
                else                             state_d = RELEASE;
            end
            default:                             state_d = CPU_IDLE;
        endcase
    end

    // datapath and registered outputs; a drain entered right after a completed
    // CPU cycle is already at a boundary, so drain_ready skips the wait
    always_comb begin
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rw_d          = rw_q;
        dout_d        = dout_q;
        drdata_d      = drdata_q;
        cs_d          = 1'b0;
        we_d          = 1'b0;
        oe_d          = 1'b0;
        rd_ready_d    = 1'b0;
        cnt_d         = {CNT_W{1'b0}};
        drain_ready_d = 1'b0;
        grant_d       = (state_d == DIAG_OWN);
        case (state_q)
            CPU_IDLE: begin
                if (phi2_rise_s) begin
                    addr_d = cpu_address;
                    rw_d   = rw_lvl_s;
                    cs_d   = 1'b1;
                end else begin
                    cs_d   = 1'b0;
                end
            end
            CPU_ACTIVE: begin
                cs_d       = 1'b1;
                rd_ready_d = 1'b1;
                if (rw_q && rd_ready_q) begin
                    dout_d = mem_rdata;
                    oe_d   = 1'b1;
                end else begin
                    oe_d   = 1'b0;
                end
                if (phi2_fall_s) begin
                    oe_d          = 1'b0;
                    drain_ready_d = halt;
                    if (rw_q) begin
                        cs_d    = 1'b0;
                    end else begin
                        wdata_d = cpu_data_in;
                        we_d    = 1'b1;
                    end
                end else begin
                    drain_ready_d = 1'b0;
                end
            end
            DRAIN: begin
                cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                drain_ready_d = drain_ready_q;
            end
            DIAG_OWN: begin
                drdata_d = mem_rdata;
            end
            RELEASE: begin
                cs_d = 1'b0;
            end
            default: begin
                cs_d = 1'b0;
            end
        endcase
    end

    assign own_s        = (state_q == DIAG_OWN);
    assign mem_address  = own_s ? diag_address : addr_q;
    assign mem_wdata    = own_s ? diag_wdata : wdata_q;
    assign mem_cs       = own_s ? diag_cs : cs_q;
    assign mem_we       = own_s ? (diag_we & diag_cs) : we_q;
    assign cpu_data_out = dout_q;
    assign cpu_data_oe  = oe_q;
    assign diag_grant   = grant_q;
    assign diag_rdata   = drdata_q;

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Scoreboard bench: stimulus pushes expected reads/writes, a negedge monitor
// pops and compares; a sparse reference memory supplies expected read data.
module tb_cpu_memory_arbiter;

    localparam int SS = 2;
    localparam int DT = 64;

    logic        fpga_clk = 1'b0;
    logic        fpga_reset;
    logic        cpu_phi2, cpu_rw, halt, diag_we, diag_cs;
    logic [15:0] cpu_address, diag_address, mem_address;
    logic [7:0]  cpu_data_in, diag_wdata, cpu_data_out, diag_rdata, mem_wdata;
    logic        cpu_data_oe, diag_grant, mem_we, mem_cs;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  ram [0:65535];
    bit          ram_ready = 1'b0;
    logic [7:0]  ref_mem [logic [15:0]];

    logic [7:0]  rd_q [$];
    logic [23:0] wr_q [$];
    logic [7:0]  dg_q [$];
    logic        dg_chk;
    logic [7:0]  last_dg;
    int          n_vec = 0;
    int          n_err = 0;
    int          grant_lat;

    cpu_memory_arbiter #(.ADDR_WIDTH(16), .SYNC_STAGES(SS), .DRAIN_TIMEOUT(DT)) dut (
        .fpga_clk(fpga_clk), .fpga_reset(fpga_reset),
        .cpu_phi2(cpu_phi2), .cpu_rw(cpu_rw), .cpu_address(cpu_address),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe),
        .halt(halt), .diag_grant(diag_grant),
        .diag_address(diag_address), .diag_wdata(diag_wdata), .diag_we(diag_we),
        .diag_cs(diag_cs), .diag_rdata(diag_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_cs(mem_cs), .mem_rdata(mem_rdata)
    );

    always #5 fpga_clk = ~fpga_clk;

    function automatic logic [7:0] init_pat(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_pat(a);
    endfunction

    // the physical RAM: registered read, data valid one cycle after the address
    always @(posedge fpga_clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_pat(16'(i));
            ram_ready <= 1'b1;
        end else if (mem_cs) begin
            if (mem_we) ram[mem_address] <= mem_wdata;
            mem_rdata <= ram[mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares each DUT presentation against the scoreboard queues
    initial begin
        logic        oe_prev;
        logic [23:0] e;
        oe_prev = 1'b0;
        forever begin
            @(negedge fpga_clk);
            if (cpu_data_oe && !oe_prev) begin
                if (rd_q.size() == 0) check("cpu_rd_unexpected", 32'(rd_q.size()), 32'd1);
                else check("cpu_rd_data", {24'h0, cpu_data_out}, {24'h0, rd_q.pop_front()});
            end
            oe_prev = cpu_data_oe;
            if (mem_we) begin
                if (wr_q.size() == 0) check("mem_we_unexpected", 32'(wr_q.size()), 32'd1);
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {16'h0, mem_address}, {16'h0, e[23:8]});
                    check("wr_data", {24'h0, mem_wdata}, {24'h0, e[7:0]});
                end
            end
            if (dg_chk) begin
                if (dg_q.size() == 0) check("diag_rd_unexpected", 32'(dg_q.size()), 32'd1);
                else check("diag_rdata", {24'h0, diag_rdata}, {24'h0, dg_q.pop_front()});
            end
        end
    end

    task automatic wait_grant(input logic want, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge fpga_clk);
            n++;
            #1;
            if (diag_grant == want) break;
        end
    endtask

    task automatic cpu_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d,
                             input logic raise_halt);
        @(posedge fpga_clk); #2;
        cpu_rw = rw; cpu_address = a; cpu_data_in = d;
        repeat (2) @(posedge fpga_clk);
        #4 cpu_phi2 = 1'b1;
        repeat (4) @(posedge fpga_clk);
        #2 if (raise_halt) halt = 1'b1;
        repeat (6) @(posedge fpga_clk);
        #1;
        if (rw) check("rd_before_fall", 32'(rd_q.size()), 32'd0);
        if (raise_halt) check("grant_during_phi2", {31'h0, diag_grant}, 32'd0);
        #2 cpu_phi2 = 1'b0;
        if (raise_halt) wait_grant(1'b1, 20, grant_lat);
        else repeat (8) @(posedge fpga_clk);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        rd_q.push_back(ref_read(a));
        cpu_cycle(1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        ref_mem[a] = d;
        cpu_cycle(1'b0, a, d, 1'b0);
    endtask

    task automatic diag_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge fpga_clk); #2;
        diag_address = a; diag_wdata = d; diag_we = 1'b1; diag_cs = 1'b1;
        wr_q.push_back({a, d});
        ref_mem[a] = d;
        @(posedge fpga_clk); #2;
        diag_we = 1'b0; diag_cs = 1'b0;
    endtask

    task automatic diag_read(input logic [15:0] a);
        @(posedge fpga_clk); #2;
        diag_address = a; diag_we = 1'b0; diag_cs = 1'b1;
        repeat (2) @(posedge fpga_clk);
        #2;
        last_dg = ref_read(a);
        dg_q.push_back(last_dg);
        dg_chk = 1'b1;
        @(posedge fpga_clk); #2;
        dg_chk = 1'b0; diag_cs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] a;
        fpga_reset = 1'b0; cpu_phi2 = 1'b0; cpu_rw = 1'b1; halt = 1'b0;
        cpu_address = 16'h0000; cpu_data_in = 8'h00;
        diag_address = 16'h0000; diag_wdata = 8'h00; diag_we = 1'b0; diag_cs = 1'b0;
        dg_chk = 1'b0; last_dg = 8'h00; grant_lat = 0;

        repeat (3) @(posedge fpga_clk);
        #2;
        check("rst_cpu_data_out", {24'h0, cpu_data_out}, 32'h0);
        check("rst_cpu_data_oe", {31'h0, cpu_data_oe}, 32'h0);
        check("rst_diag_grant", {31'h0, diag_grant}, 32'h0);
        check("rst_diag_rdata", {24'h0, diag_rdata}, 32'h0);
        check("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_address", {16'h0, mem_address}, 32'h0);
        fpga_reset = 1'b1;
        repeat (4) @(posedge fpga_clk);

        // basic read, write then read-back
        cpu_read(16'h1234);
        cpu_write(16'h8000, 8'h3C);
        cpu_read(16'h8000);

        // random CPU traffic, concentrated on a few addresses so reads hit writes
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) a = 16'($urandom);
            else a = {13'h0200, 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 1) == 1) cpu_write(a, 8'($urandom));
            else cpu_read(a);
        end

        // halt raised while phi2 is high
        rd_q.push_back(ref_read(16'h8000));
        cpu_cycle(1'b1, 16'h8000, 8'h00, 1'b1);
        check("halt_grant_latency_in_range",
              {31'h0, (grant_lat >= SS + 1) && (grant_lat <= SS + 2)}, 32'd1);

        // diagnostics sweep while granted
        for (int i = 0; i < 256; i++) diag_write(16'(i), 8'(i));
        for (int i = 0; i < 256; i++) diag_read(16'(i));
        for (int i = 0; i < 8; i++) diag_read(16'($urandom));
        @(posedge fpga_clk); #2 halt = 1'b0;
        wait_grant(1'b0, 20, n);
        check("release_grant_low", {31'h0, diag_grant}, 32'd0);
        repeat (4) @(posedge fpga_clk);
        #1 check("diag_rdata_hold", {24'h0, diag_rdata}, {24'h0, last_dg});

        // diagnostics strobes while the CPU owns the memory must not write
        #1 diag_address = 16'h0042; diag_wdata = 8'hFF; diag_we = 1'b1; diag_cs = 1'b1;
        repeat (6) @(posedge fpga_clk);
        #2 diag_we = 1'b0; diag_cs = 1'b0;
        cpu_read(16'h0042);
        check("diag_rdata_hold_cpu", {24'h0, diag_rdata}, {24'h0, last_dg});

        // stopped CPU clock: grant exactly DRAIN_TIMEOUT cycles after entering DRAIN
        repeat (4) @(posedge fpga_clk);
        #2 halt = 1'b1;
        wait_grant(1'b1, 200, n);
        check("drain_timeout_cycles", 32'(n), 32'(DT + 1));
        @(posedge fpga_clk); #2 halt = 1'b0;
        wait_grant(1'b0, 20, n);
        check("timeout_release", {31'h0, diag_grant}, 32'd0);
        repeat (4) @(posedge fpga_clk);
        cpu_read(16'h1234);

        // reset during a diagnostics write
        #2 halt = 1'b1;
        wait_grant(1'b1, 200, n);
        check("grant_before_reset", {31'h0, diag_grant}, 32'd1);
        @(posedge fpga_clk); #2;
        diag_address = 16'h0777; diag_wdata = 8'hE1; diag_we = 1'b1; diag_cs = 1'b1;
        wr_q.push_back({16'h0777, 8'hE1});
        ref_mem[16'h0777] = 8'hE1;
        @(posedge fpga_clk);
        #3 fpga_reset = 1'b0;
        #1;
        check("async_rst_mem_we", {31'h0, mem_we}, 32'd0);
        check("async_rst_mem_cs", {31'h0, mem_cs}, 32'd0);
        check("async_rst_grant", {31'h0, diag_grant}, 32'd0);
        diag_we = 1'b0; diag_cs = 1'b0; halt = 1'b0;
        repeat (3) @(posedge fpga_clk);
        #2 fpga_reset = 1'b1;
        repeat (4) @(posedge fpga_clk);
        cpu_read(16'h0777);

        repeat (4) @(posedge fpga_clk);
        check("queues_drained", 32'(rd_q.size() + wr_q.size() + dg_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
